// File: rtl/iq_stream_deframer_pkg.sv
// -----------------------------------------------------------------------------
// iq_stream_deframer_pkg
// Shared definitions for the I/Q stream deframer:
//   - default channel count and word width used by the VVM DSP chain
//   - frame word order (I at even index, Q at odd index) and the index helper
//   - deframer FSM state encoding
// -----------------------------------------------------------------------------
package iq_stream_deframer_pkg;

  localparam int DEF_N_CH = 4;
  localparam int DEF_DW   = 21;

  // Position of a component inside one channel's word pair.
  localparam int IQ_I = 0;
  localparam int IQ_Q = 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  // Frame word index of component iq (IQ_I/IQ_Q) of channel ch.
  function automatic int iq_idx(input int ch, input int iq);
    return (2 * ch) + iq;
  endfunction

endpackage

// File: rtl/iq_round_sat.sv
// -----------------------------------------------------------------------------
// iq_round_sat
// Combinational width reduction of a signed word: round half up by S=DW-OUT_DW
// bits, then saturate to the signed OUT_DW range. S=0 is a plain pass-through.
// Ports:
//   i_word  in  DW      signed input word
//   o_word  out OUT_DW  rounded and saturated word
// -----------------------------------------------------------------------------
module iq_round_sat #(
  parameter int DW     = 21,
  parameter int OUT_DW = 21
) (
  input  logic [DW-1:0]     i_word,
  output logic [OUT_DW-1:0] o_word
);

  localparam int S = DW - OUT_DW;

  generate
    if (S == 0) begin : g_pass
      assign o_word = i_word;
    end else begin : g_round
      localparam logic [DW:0] HALF = (DW + 1)'(1) << (S - 1);

      // One guard bit above the output width catches overflow from rounding.
      logic [OUT_DW:0] w_shr;
      assign w_shr = (OUT_DW + 1)'(({i_word[DW-1], i_word} + HALF) >> S);

      // Guard bit disagreeing with the output sign bit means out of range.
      always_comb begin
        if (w_shr[OUT_DW] != w_shr[OUT_DW-1]) begin
          o_word = w_shr[OUT_DW] ? {1'b1, {(OUT_DW - 1){1'b0}}}
                                 : {1'b0, {(OUT_DW - 1){1'b1}}};
        end else begin
          o_word = w_shr[OUT_DW-1:0];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/iq_stream_deframer.sv
// -----------------------------------------------------------------------------
// iq_stream_deframer
// Deserialises the time-multiplexed I/Q stream (I0,Q0,...,I(N-1),Q(N-1)) into
// a parallel register bank, with width reduction, abort detection, a frame
// counter and a selectable single-channel tap.
// Ports:
//   sample_clk    in   sample clock, rising edge
//   sample_rst_n  in   asynchronous active-low reset
//   stream_in     in   signed I/Q word, valid while strobe_in=1
//   strobe_in     in   word valid; 2*N_CH contiguous cycles per frame
//   clear_err     in   pulse; clears frame_err (an abort in the same cycle wins)
//   sel           in   channel index for the i_sel/q_sel tap
//   iq_flat       out  {Q(N-1),I(N-1),...,Q0,I0}, I0 in the LSBs
//   i_sel, q_sel  out  I/Q of channel sel; 0 when sel >= N_CH
//   strobe_out    out  one-cycle pulse when iq_flat/i_sel/q_sel just updated
//   frame_err     out  sticky: a frame was aborted
//   frame_cnt     out  number of complete frames, wrapping
// -----------------------------------------------------------------------------
module iq_stream_deframer
  import iq_stream_deframer_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int DW     = DEF_DW,
  parameter int OUT_DW = DEF_DW,
  parameter int FCNT_W = 16,
  // Sized to hold N_CH itself so an out-of-range channel can be addressed.
  localparam int SEL_W = $clog2(N_CH + 1)
) (
  input  logic                     sample_clk,
  input  logic                     sample_rst_n,
  input  logic [DW-1:0]            stream_in,
  input  logic                     strobe_in,
  input  logic                     clear_err,
  input  logic [SEL_W-1:0]         sel,
  output logic [2*N_CH*OUT_DW-1:0] iq_flat,
  output logic [OUT_DW-1:0]        i_sel,
  output logic [OUT_DW-1:0]        q_sel,
  output logic                     strobe_out,
  output logic                     frame_err,
  output logic [FCNT_W-1:0]        frame_cnt
);

  localparam int NW     = 2 * N_CH;
  localparam int IDX_W  = $clog2(NW);
  localparam int FLAT_W = NW * OUT_DW;

  state_e                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [OUT_DW-1:0]     r_shadow [NW];
  logic [FLAT_W-1:0]     r_iq_flat;
  logic [OUT_DW-1:0]     r_i_sel;
  logic [OUT_DW-1:0]     r_q_sel;
  logic                  r_strobe_out;
  logic                  r_frame_err;
  logic [FCNT_W-1:0]     r_frame_cnt;

  logic [OUT_DW-1:0]     w_word;
  logic                  w_last;
  logic [FLAT_W-1:0]     w_next_flat;
  logic [OUT_DW-1:0]     w_i_sel;
  logic [OUT_DW-1:0]     w_q_sel;

  iq_round_sat #(
    .DW     (DW),
    .OUT_DW (OUT_DW)
  ) u_round_sat (
    .i_word (stream_in),
    .o_word (w_word)
  );

  // Final word of a frame arriving this cycle (idx is never last in IDLE).
  assign w_last = strobe_in && (r_idx == IDX_W'(NW - 1));

  // Bank contents after this edge: the shadow plus the live last word on completion.
  always_comb begin
    w_next_flat = r_iq_flat;
    if (w_last) begin
      for (int k = 0; k < NW - 1; k++) begin
        w_next_flat[k*OUT_DW +: OUT_DW] = r_shadow[k];
      end
      w_next_flat[(NW-1)*OUT_DW +: OUT_DW] = w_word;
    end else begin
      w_next_flat = r_iq_flat;
    end
  end

  // Channel tap taken from the post-edge bank so it lands together with strobe_out.
  always_comb begin
    w_i_sel = '0;
    w_q_sel = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_i_sel = (sel == SEL_W'(c)) ? w_next_flat[iq_idx(c, IQ_I)*OUT_DW +: OUT_DW] : w_i_sel;
      w_q_sel = (sel == SEL_W'(c)) ? w_next_flat[iq_idx(c, IQ_Q)*OUT_DW +: OUT_DW] : w_q_sel;
    end
  end

  // Frame FSM: word index, shadow bank, output bank, tap, error and frame counters.
  always_ff @(posedge sample_clk or negedge sample_rst_n) begin
    if (!sample_rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      for (int k = 0; k < NW; k++) begin
        r_shadow[k] <= '0;
      end
      r_iq_flat    <= '0;
      r_i_sel      <= '0;
      r_q_sel      <= '0;
      r_strobe_out <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_strobe_out <= 1'b0;
      r_i_sel      <= w_i_sel;
      r_q_sel      <= w_q_sel;
      // Cleared first so an abort later in this block overrides it.
      if (clear_err) begin
        r_frame_err <= 1'b0;
      end else begin
        r_frame_err <= r_frame_err;
      end
      case (r_state)
        ST_IDLE: begin
          if (strobe_in) begin
            r_shadow[0] <= w_word;
            r_idx       <= IDX_W'(1);
            r_state     <= ST_COLLECT;
          end else begin
            r_idx <= '0;
          end
        end
        ST_COLLECT: begin
          if (!strobe_in) begin
            r_frame_err <= 1'b1;
            r_idx       <= '0;
            r_state     <= ST_IDLE;
          end else if (w_last) begin
            r_iq_flat    <= w_next_flat;
            r_strobe_out <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + FCNT_W'(1);
            r_idx        <= '0;
            r_state      <= ST_IDLE;
          end else begin
            r_shadow[r_idx] <= w_word;
            r_idx           <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          r_idx   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign iq_flat    = r_iq_flat;
  assign i_sel      = r_i_sel;
  assign q_sel      = r_q_sel;
  assign strobe_out = r_strobe_out;
  assign frame_err  = r_frame_err;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_iq_stream_deframer.sv
// -----------------------------------------------------------------------------
// tb_iq_stream_deframer
// Self-checking bench: a full-width instance (OUT_DW=21) and a reduced-width
// instance (OUT_DW=18) share all inputs. Expected frames are queued when a
// frame is driven and popped when strobe_out is observed.
// -----------------------------------------------------------------------------
module tb_iq_stream_deframer;

  localparam int N_CH     = 4;
  localparam int DW       = 21;
  localparam int OUT_DW   = 21;
  localparam int OUT_DW_N = 18;
  localparam int FCNT_W   = 16;
  localparam int SEL_W    = $clog2(N_CH + 1);
  localparam int NW       = 2 * N_CH;
  localparam int FLAT_W   = NW * OUT_DW;
  localparam int FLAT_W_N = NW * OUT_DW_N;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [DW-1:0]       stream = '0;
  logic                strobe = 1'b0;
  logic                clear_err = 1'b0;
  logic [SEL_W-1:0]    sel = '0;

  logic [FLAT_W-1:0]   iq_flat;
  logic [OUT_DW-1:0]   i_sel, q_sel;
  logic                strobe_out, frame_err;
  logic [FCNT_W-1:0]   frame_cnt;

  logic [FLAT_W_N-1:0] n_iq_flat;
  logic [OUT_DW_N-1:0] n_i_sel, n_q_sel;
  logic                n_strobe_out, n_frame_err;
  logic [FCNT_W-1:0]   n_frame_cnt;

  int checks = 0;
  int failures = 0;

  logic [FLAT_W-1:0]   q_flat [$];
  logic [FLAT_W-1:0]   exp_hold = '0;
  logic [FCNT_W-1:0]   exp_cnt = '0;
  int                  words [NW];

  iq_stream_deframer #(.N_CH(N_CH), .DW(DW), .OUT_DW(OUT_DW), .FCNT_W(FCNT_W)) dut (
    .sample_clk(clk), .sample_rst_n(rst_n), .stream_in(stream), .strobe_in(strobe),
    .clear_err(clear_err), .sel(sel), .iq_flat(iq_flat), .i_sel(i_sel), .q_sel(q_sel),
    .strobe_out(strobe_out), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  iq_stream_deframer #(.N_CH(N_CH), .DW(DW), .OUT_DW(OUT_DW_N), .FCNT_W(FCNT_W)) dut_n (
    .sample_clk(clk), .sample_rst_n(rst_n), .stream_in(stream), .strobe_in(strobe),
    .clear_err(clear_err), .sel(sel), .iq_flat(n_iq_flat), .i_sel(n_i_sel), .q_sel(n_q_sel),
    .strobe_out(n_strobe_out), .frame_err(n_frame_err), .frame_cnt(n_frame_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge; outputs read afterwards
  // reflect the previous rising edge.
  task automatic tick(input logic stb, input int w, input logic clr);
    @(negedge clk);
    strobe    = stb;
    stream    = DW'(w);
    clear_err = clr;
  endtask

  // Queue the expected bank for words[] and drive the frame contiguously.
  task automatic send_frame();
    logic [FLAT_W-1:0] e;
    e = '0;
    for (int k = 0; k < NW; k++) e[k*OUT_DW +: OUT_DW] = OUT_DW'(words[k]);
    q_flat.push_back(e);
    exp_cnt = exp_cnt + 1'b1;
    for (int k = 0; k < NW; k++) tick(1'b1, words[k], 1'b0);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (iq_flat !== '0) begin failures++; $display("FAIL reset_iq_flat got=%h exp=0", iq_flat); end
    checks++; if (i_sel !== '0 || q_sel !== '0) begin failures++; $display("FAIL reset_sel got=%h/%h exp=0/0", i_sel, q_sel); end
    checks++; if (strobe_out !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", strobe_out, frame_err); end
    checks++; if (frame_cnt !== '0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [FLAT_W-1:0] e;
    for (int k = 0; k < NW; k++) words[k] = k + 1;
    send_frame();
    checks++; if (strobe_out !== 1'b0) begin failures++; $display("FAIL basic_early_strobe got=%b exp=0", strobe_out); end
    tick(1'b0, 0, 1'b0);
    checks++; if (strobe_out !== 1'b1) begin failures++; $display("FAIL basic_strobe got=%b exp=1", strobe_out); end
    e = q_flat.pop_front();
    checks++; if (iq_flat !== e) begin failures++; $display("FAIL basic_iq_flat got=%h exp=%h", iq_flat, e); end
    exp_hold = e;
    checks++; if (frame_cnt !== exp_cnt || frame_err !== 1'b0) begin failures++; $display("FAIL basic_cnt_err got=%0d/%b exp=%0d/0", frame_cnt, frame_err, exp_cnt); end
    tick(1'b0, 0, 1'b0);
    checks++; if (strobe_out !== 1'b0) begin failures++; $display("FAIL basic_strobe_width got=%b exp=0", strobe_out); end
  endtask

  task automatic test_abort();
    logic [FLAT_W-1:0] e;
    for (int k = 0; k < 5; k++) tick(1'b1, 21 + k, 1'b0);
    tick(1'b0, 0, 1'b0);
    checks++; if (strobe_out !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL abort_pre got=%b%b exp=00", strobe_out, frame_err); end
    tick(1'b0, 0, 1'b0);
    checks++; if (strobe_out !== 1'b0 || frame_err !== 1'b1) begin failures++; $display("FAIL abort_err got=%b%b exp=01", strobe_out, frame_err); end
    checks++; if (iq_flat !== exp_hold || frame_cnt !== exp_cnt) begin failures++; $display("FAIL abort_hold got=%h/%0d exp=%h/%0d", iq_flat, frame_cnt, exp_hold, exp_cnt); end
    for (int k = 0; k < NW; k++) words[k] = 11 + k;
    send_frame();
    tick(1'b0, 0, 1'b0);
    checks++; if (strobe_out !== 1'b1) begin failures++; $display("FAIL abort_next_strobe got=%b exp=1", strobe_out); end
    e = q_flat.pop_front();
    checks++; if (iq_flat !== e || iq_flat[OUT_DW-1:0] !== OUT_DW'(11)) begin failures++; $display("FAIL abort_next_flat got=%h exp=%h", iq_flat, e); end
    exp_hold = e;
    tick(1'b0, 0, 1'b1);
    tick(1'b0, 0, 1'b0);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL clear_err got=%b exp=0", frame_err); end
    // Abort and clear in the same cycle: the abort must win.
    for (int k = 0; k < 3; k++) tick(1'b1, 70 + k, 1'b0);
    tick(1'b0, 0, 1'b1);
    tick(1'b0, 0, 1'b0);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL abort_beats_clear got=%b exp=1", frame_err); end
    tick(1'b0, 0, 1'b1);
    tick(1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [FLAT_W-1:0] e;
    int first, second, seen;
    first = -1; second = -1; seen = 0;
    for (int f = 0; f < 2; f++) begin
      e = '0;
      for (int k = 0; k < NW; k++) e[k*OUT_DW +: OUT_DW] = OUT_DW'(31 + f*NW + k);
      q_flat.push_back(e);
      exp_cnt = exp_cnt + 1'b1;
    end
    for (int j = 0; j < 2*NW + 2; j++) begin
      tick(j < 2*NW, 31 + j, 1'b0);
      if (strobe_out === 1'b1) begin
        seen++;
        if (first < 0) first = j; else second = j;
        checks++;
        if (q_flat.size() == 0) begin failures++; $display("FAIL b2b_extra_strobe at=%0d exp=none", j); end
        else begin
          e = q_flat.pop_front();
          if (iq_flat !== e) begin failures++; $display("FAIL b2b_iq_flat got=%h exp=%h", iq_flat, e); end
          exp_hold = e;
        end
      end
    end
    checks++; if (seen != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", seen); end
    checks++; if (first != NW || second - first != NW) begin failures++; $display("FAIL b2b_spacing got=%0d,%0d exp=%0d,%0d", first, second, NW, 2*NW); end
    checks++; if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL b2b_frame_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_round();
    int in_v [4];
    int out_v [4];
    logic [OUT_DW_N-1:0] e18;
    in_v[0] = 12;      out_v[0] = 2;
    in_v[1] = -12;     out_v[1] = -1;
    in_v[2] = 1048575; out_v[2] = 131071;
    in_v[3] = -1048576; out_v[3] = -131072;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NW; k++) words[k] = 0;
      words[0] = in_v[i];
      send_frame();
      tick(1'b0, 0, 1'b0);
      e18 = OUT_DW_N'(out_v[i]);
      checks++;
      if (n_strobe_out !== 1'b1 || n_iq_flat[OUT_DW_N-1:0] !== e18) begin
        failures++; $display("FAIL round_case%0d in=%0d got=%h exp=%h", i, in_v[i], n_iq_flat[OUT_DW_N-1:0], e18);
      end
      exp_hold = q_flat.pop_front();
      checks++; if (iq_flat !== exp_hold) begin failures++; $display("FAIL round_full_width%0d got=%h exp=%h", i, iq_flat, exp_hold); end
    end
  endtask

  task automatic test_reset_mid();
    logic [FLAT_W-1:0] e;
    for (int k = 0; k < 3; k++) tick(1'b1, 90 + k, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (iq_flat !== '0 || frame_cnt !== '0 || i_sel !== '0 || q_sel !== '0 || frame_err !== 1'b0 || strobe_out !== 1'b0) begin
      failures++; $display("FAIL async_reset got=%h/%0d exp=0/0", iq_flat, frame_cnt);
    end
    exp_cnt = '0; exp_hold = '0; q_flat.delete();
    tick(1'b0, 0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < NW; k++) words[k] = 51 + k;
    send_frame();
    tick(1'b0, 0, 1'b0);
    e = q_flat.pop_front();
    checks++; if (strobe_out !== 1'b1 || iq_flat !== e) begin failures++; $display("FAIL reset_refill got=%b/%h exp=1/%h", strobe_out, iq_flat, e); end
    exp_hold = e;
    checks++; if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL reset_refill_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_sel();
    sel = SEL_W'(2);
    for (int k = 0; k < NW; k++) words[k] = k + 1;
    send_frame();
    tick(1'b0, 0, 1'b0);
    exp_hold = q_flat.pop_front();
    checks++; if (strobe_out !== 1'b1 || i_sel !== OUT_DW'(5) || q_sel !== OUT_DW'(6)) begin
      failures++; $display("FAIL sel2 got=%b/%0d/%0d exp=1/5/6", strobe_out, i_sel, q_sel);
    end
    sel = SEL_W'(7);
    tick(1'b0, 0, 1'b0);
    checks++; if (i_sel !== '0 || q_sel !== '0) begin failures++; $display("FAIL sel_oob got=%0d/%0d exp=0/0", i_sel, q_sel); end
    sel = SEL_W'(3);
    tick(1'b0, 0, 1'b0);
    checks++; if (i_sel !== OUT_DW'(7) || q_sel !== OUT_DW'(8)) begin failures++; $display("FAIL sel3 got=%0d/%0d exp=7/8", i_sel, q_sel); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_back_to_back();
    test_round();
    test_reset_mid();
    test_sel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
